// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU: default field widths, ALU opcodes,
// the ID->EXE bundle layout and the skid buffer state encoding.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ALUC_W_DEF = 4;
    localparam int RA_W_DEF   = 5;
    localparam int CNT_W_DEF  = 16;

    localparam logic [ALUC_W_DEF-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALUC_W_DEF-1:0] ALU_AND = 4'b0001;
    localparam logic [ALUC_W_DEF-1:0] ALU_XOR = 4'b0010;
    localparam logic [ALUC_W_DEF-1:0] ALU_SLL = 4'b0011;
    localparam logic [ALUC_W_DEF-1:0] ALU_SUB = 4'b0100;
    localparam logic [ALUC_W_DEF-1:0] ALU_OR  = 4'b0101;
    localparam logic [ALUC_W_DEF-1:0] ALU_LUI = 4'b0110;
    localparam logic [ALUC_W_DEF-1:0] ALU_SRL = 4'b0111;
    localparam logic [ALUC_W_DEF-1:0] ALU_SRA = 4'b1111;

    // Encoded as {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b10,
        SKID_FULL  = 2'b11
    } skid_state_e;

    // Field order matches the packed bus used by id_exe_pipe_reg.
    typedef struct packed {
        logic                  wreg;
        logic                  m2reg;
        logic                  wmem;
        logic [ALUC_W_DEF-1:0] aluc;
        logic                  aluimm;
        logic [DATA_W_DEF-1:0] qa;
        logic [DATA_W_DEF-1:0] qb;
        logic [DATA_W_DEF-1:0] imm;
        logic [RA_W_DEF-1:0]   rd;
    } idex_bundle_t;

    function automatic int idex_width(input int data_w, input int aluc_w, input int ra_w);
        return 4 + aluc_w + 3 * data_w + ra_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// in_ready depends only on registered state, so there is no ready path from out to in.
module pipe_skid_buf
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output skid_state_e      state
);

    // Handshake: a transfer happens on an edge where valid & ready are both high;
    // a producer holds valid and data stable until that edge.
    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept, consume;

    assign in_ready  = (state_q != SKID_FULL);
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = main_q;
    assign state     = state_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = SKID_FULL;
                    end else if (consume) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    // in_ready is low here, so only the skid entry can advance.
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register: packs decode fields into a skid buffer, gates the
// write enables with ex_valid and counts EXE bubble cycles.
module id_exe_pipe_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ALUC_W = ALUC_W_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic              id_wmem,
    input  logic [ALUC_W-1:0] id_aluc,
    input  logic              id_aluimm,
    input  logic [DATA_W-1:0] id_qa,
    input  logic [DATA_W-1:0] id_qb,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [RA_W-1:0]   id_rd,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic              ex_wreg,
    output logic              ex_m2reg,
    output logic              ex_wmem,
    output logic [ALUC_W-1:0] ex_aluc,
    output logic              ex_aluimm,
    output logic [DATA_W-1:0] ex_qa,
    output logic [DATA_W-1:0] ex_qb,
    output logic [DATA_W-1:0] ex_imm,
    output logic [RA_W-1:0]   ex_rd,
    output logic [CNT_W-1:0]  bubble_cnt,
    output skid_state_e       dbg_state
);

    localparam int BUS_W = idex_width(DATA_W, ALUC_W, RA_W);

    logic [BUS_W-1:0] id_bus, ex_bus;
    logic             ex_wreg_raw, ex_wmem_raw;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    assign id_bus = {id_wreg, id_m2reg, id_wmem, id_aluc, id_aluimm,
                     id_qa, id_qb, id_imm, id_rd};

    pipe_skid_buf #(.WIDTH(BUS_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (id_valid),
        .in_ready  (id_ready),
        .in_data   (id_bus),
        .out_valid (ex_valid),
        .out_ready (ex_ready),
        .out_data  (ex_bus),
        .state     (dbg_state)
    );

    assign {ex_wreg_raw, ex_m2reg, ex_wmem_raw, ex_aluc, ex_aluimm,
            ex_qa, ex_qb, ex_imm, ex_rd} = ex_bus;

    // A bubble must never write the regfile or memory.
    assign ex_wreg = ex_wreg_raw & ex_valid;
    assign ex_wmem = ex_wmem_raw & ex_valid;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!ex_valid && ex_ready && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule
